// File: rtl/collide_pkg.sv
// Shared types and constants for the ball collision probe.
// Bitmap addressing assumes a 640-pixel-wide playfield.
package collide_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int ADDR_W    = 19;
  localparam int CW        = 11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    UPDATE
  } state_e;

  localparam logic [1:0] PROBE_L = 2'd0;
  localparam logic [1:0] PROBE_R = 2'd1;
  localparam logic [1:0] PROBE_T = 2'd2;
  localparam logic [1:0] PROBE_B = 2'd3;

  // y*640 + x built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [9:0] x,
    input logic [9:0] y
  );
    logic [ADDR_W-1:0] yy;
    logic [ADDR_W-1:0] xx;
    yy = {9'd0, y};
    xx = {9'd0, x};
    return (yy << 9) + (yy << 7) + xx;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with rising-edge detect for the frame tick.
// A level already high when reset releases is absorbed, not reported.
module sync_rise (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q_rise
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [1:0] arm_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      arm_q <= 2'd0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  // edge history is only trusted once the whole chain holds real samples
  assign q_rise = s2_q & ~s3_q & (arm_q == 2'd3);

endmodule

// File: rtl/ball_collide.sv
// Probes the four pixels just outside the ball once per frame tick
// and reports which sides touch solid playfield.
module ball_collide
  import collide_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic [9:0]        BallS,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rdata,
  output logic              bit_on,
  output logic [3:0]        hit_dir,
  output logic              busy,
  output logic              overrun
);

  localparam logic signed [CW-1:0] XLIM = CW'(H_RES);
  localparam logic signed [CW-1:0] YLIM = CW'(V_RES);
  localparam logic signed [CW-1:0] ONE  = 11'sd1;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] res_q, res_d;
  logic [9:0] bx_q, by_q, bs_q;
  logic       pend_q;
  logic [1:0] pidx_q;
  logic       bit_on_q;
  logic [3:0] hit_q;
  logic       ovr_q;
  logic       tick;

  logic signed [CW-1:0] sx, sy, ss;
  logic signed [CW-1:0] px, py;
  logic                 in_rng;

  sync_rise u_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (frame_clk),
    .q_rise  (tick)
  );

  assign sx = $signed({1'b0, bx_q});
  assign sy = $signed({1'b0, by_q});
  assign ss = $signed({1'b0, bs_q});

  always_comb begin
    px = sx;
    py = sy;
    case (cnt_q)
      PROBE_L: px = sx - ss - ONE;
      PROBE_R: px = sx + ss + ONE;
      PROBE_T: py = sy - ss - ONE;
      PROBE_B: py = sy + ss + ONE;
      default: ;
    endcase
  end

  assign in_rng = ~px[CW-1] & ~py[CW-1]
                & (px < XLIM) & (py < YLIM);

  assign mem_rd   = (state_q == ISSUE) & in_rng;
  assign mem_addr = mem_rd ? pix_addr(px[9:0], py[9:0])
                           : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ISSUE;
          cnt_d   = 2'd0;
          res_d   = 4'd0;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == PROBE_B) state_d = DRAIN;
      end
      DRAIN:   state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // read data belongs to the probe issued one cycle earlier
    if (pend_q) res_d[pidx_q] = mem_rdata;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      res_q    <= 4'd0;
      bx_q     <= 10'd0;
      by_q     <= 10'd0;
      bs_q     <= 10'd0;
      pend_q   <= 1'b0;
      pidx_q   <= 2'd0;
      bit_on_q <= 1'b0;
      hit_q    <= 4'd0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      pend_q  <= mem_rd;
      pidx_q  <= cnt_q;
      if (state_q == IDLE && tick) begin
        bx_q <= BallX;
        by_q <= BallY;
        bs_q <= BallS;
      end
      if (state_q != IDLE && tick) ovr_q <= 1'b1;
      if (state_q == UPDATE) begin
        hit_q    <= {res_q[PROBE_T], res_q[PROBE_B],
                     res_q[PROBE_L], res_q[PROBE_R]};
        bit_on_q <= res_q[PROBE_L] | res_q[PROBE_R];
      end
    end
  end

  assign bit_on  = bit_on_q;
  assign hit_dir = hit_q;
  assign busy    = (state_q != IDLE);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_ball_collide.sv
// Self-checking bench for ball_collide with a bitmap memory model
// and a coordinate-level reference of the four edge probes.
module tb_ball_collide;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [9:0]  BallX, BallY, BallS;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic        mem_rdata;
  logic        bit_on;
  logic [3:0]  hit_dir;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  bit   solid[int];
  bit   force_one = 1'b0;
  int   addr_q[$];
  int   exp_q[$];
  logic [3:0] exp_hit;
  bit   rd_n = 1'b0;
  bit   val_n = 1'b0;
  bit   busy_prev = 1'b0;
  int   busy_falls = 0;

  always #5 Clk = ~Clk;

  ball_collide dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .BallX     (BallX),
    .BallY     (BallY),
    .BallS     (BallS),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .bit_on    (bit_on),
    .hit_dir   (hit_dir),
    .busy      (busy),
    .overrun   (overrun)
  );

  always @(negedge Clk) begin
    rd_n  = mem_rd;
    val_n = solid.exists(int'(mem_addr));
    if (mem_rd === 1'b1) addr_q.push_back(int'(mem_addr));
    else if (busy === 1'b1) begin
      checks++;
      if (mem_addr !== 19'd0) begin
        errors++;
        $display("FAIL addr_idle got %0d want 0", mem_addr);
      end
    end
    if (busy_prev && busy === 1'b0) busy_falls++;
    busy_prev = (busy === 1'b1);
  end

  always @(posedge Clk)
    mem_rdata <= force_one ? 1'b1 : (rd_n ? val_n : 1'($urandom));

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic model(input int x, input int y, input int s,
                       input bit frc);
    int px[4];
    int py[4];
    bit r[4];
    px = '{x - s - 1, x + s + 1, x, x};
    py = '{y, y, y - s - 1, y + s + 1};
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      r[i] = 1'b0;
      if (px[i] >= 0 && px[i] < 640 && py[i] >= 0 && py[i] < 480) begin
        exp_q.push_back(py[i] * 640 + px[i]);
        r[i] = frc || solid.exists(py[i] * 640 + px[i]);
      end
    end
    exp_hit = {r[2], r[3], r[0], r[1]};
  endtask

  function automatic bit addrs_ok();
    if (addr_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < exp_q.size(); i++)
      if (addr_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_frame(input int x, input int y, input int s);
    @(negedge Clk);
    BallX = 10'(x);
    BallY = 10'(y);
    BallS = 10'(s);
    addr_q.delete();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    frame_clk = 1'b1;
    BallX = 10'd320;
    BallY = 10'd240;
    BallS = 10'd4;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bit_on, hit_dir, busy, overrun, mem_rd} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0",
               {bit_on, hit_dir, busy, overrun, mem_rd});
    end
    checks++;
    if (mem_addr !== 19'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d want 0", mem_addr);
    end
    addr_q.delete();
    Reset_n = 1'b1;
    repeat (12) @(negedge Clk);
    checks++;
    if (addr_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL high_at_release reads %0d busy %b want 0 0",
               addr_q.size(), busy);
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_basic();
    int want[4];
    want = '{153915, 153925, 150720, 157120};
    solid.delete();
    do_frame(320, 240, 4);
    checks++;
    if (addr_q.size() != 4 || addr_q[0] != want[0] ||
        addr_q[1] != want[1] || addr_q[2] != want[2] ||
        addr_q[3] != want[3]) begin
      errors++;
      $display("FAIL basic_addrs got n=%0d want 4 (153915..157120)",
               addr_q.size());
    end
    checks++;
    if (bit_on !== 1'b0 || hit_dir !== 4'b0000) begin
      errors++;
      $display("FAIL basic_hit got %b/%b want 0/0000", bit_on, hit_dir);
    end
  endtask

  task automatic test_latency();
    solid.delete();
    solid[153915] = 1'b1;
    @(negedge Clk);
    BallX = 10'd320;
    BallY = 10'd240;
    BallS = 10'd4;
    addr_q.delete();
    frame_clk = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge Clk);
      #1;
      if (cyc == 8) begin
        checks++;
        if (bit_on !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL lat_early bit_on %b busy %b want 0 1",
                   bit_on, busy);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (bit_on !== 1'b1 || hit_dir !== 4'b0010 || busy !== 1'b0) begin
          errors++;
          $display("FAIL lat_update got %b/%b busy %b want 1/0010 0",
                   bit_on, hit_dir, busy);
        end
      end
    end
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    checks++;
    if (bit_on !== 1'b1 || hit_dir !== 4'b0010) begin
      errors++;
      $display("FAIL lat_hold got %b/%b want 1/0010", bit_on, hit_dir);
    end
  endtask

  task automatic test_bottom();
    solid.delete();
    solid[245 * 640 + 320] = 1'b1;
    do_frame(320, 240, 4);
    checks++;
    if (bit_on !== 1'b0 || hit_dir !== 4'b0100) begin
      errors++;
      $display("FAIL bottom_hit got %b/%b want 0/0100", bit_on, hit_dir);
    end
  endtask

  task automatic test_left_edge();
    solid.delete();
    force_one = 1'b1;
    model(4, 240, 4, 1'b1);
    do_frame(4, 240, 4);
    force_one = 1'b0;
    checks++;
    if (addr_q.size() != 3 || !addrs_ok()) begin
      errors++;
      $display("FAIL edge_reads got n=%0d want 3", addr_q.size());
    end
    checks++;
    if (hit_dir !== exp_hit || bit_on !== 1'b1 || hit_dir[1] !== 1'b0) begin
      errors++;
      $display("FAIL edge_hit got %b/%b want 1/%b", bit_on, hit_dir, exp_hit);
    end
  endtask

  task automatic test_overrun();
    int x, y, s, f0;
    x = $urandom_range(50, 590);
    y = $urandom_range(50, 430);
    s = $urandom_range(1, 20);
    solid.delete();
    solid[y * 640 + x - s - 1] = 1'($urandom);
    solid[y * 640 + x + s + 1] = 1'b1;
    solid[(y - s - 1) * 640 + x] = 1'($urandom);
    model(x, y, s, 1'b0);
    f0 = busy_falls;
    @(negedge Clk);
    BallX = 10'(x);
    BallY = 10'(y);
    BallS = 10'(s);
    addr_q.delete();
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b1;
    BallX = 10'(x + 7);
    BallY = 10'(y - 9);
    BallS = 10'(s + 3);
    repeat (14) @(negedge Clk);
    frame_clk = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %b want 1", overrun);
    end
    checks++;
    if (busy_falls - f0 != 1 || !addrs_ok()) begin
      errors++;
      $display("FAIL overrun_single updates %0d reads %0d want 1 %0d",
               busy_falls - f0, addr_q.size(), exp_q.size());
    end
    checks++;
    if (hit_dir !== exp_hit || bit_on !== (exp_hit[1] | exp_hit[0])) begin
      errors++;
      $display("FAIL overrun_hit got %b want %b", hit_dir, exp_hit);
    end
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    solid.delete();
    solid[100 * 640 + 94] = 1'b1;
    do_frame(100, 100, 5);
    @(negedge Clk);
    addr_q.delete();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (busy !== 1'b1 || bit_on !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre busy %b bit_on %b want 1 1", busy, bit_on);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({bit_on, hit_dir, busy, overrun, mem_rd} !== 8'd0 ||
        mem_addr !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset got %b addr %0d want 0",
               {bit_on, hit_dir, busy, overrun, mem_rd}, mem_addr);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    addr_q.delete();
    repeat (12) @(negedge Clk);
    checks++;
    if (bit_on !== 1'b0 || hit_dir !== 4'd0 || busy !== 1'b0 ||
        addr_q.size() != 0) begin
      errors++;
      $display("FAIL mid_after got %b/%b busy %b reads %0d want 0",
               bit_on, hit_dir, busy, addr_q.size());
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    model(100, 100, 5, 1'b0);
    do_frame(100, 100, 5);
    checks++;
    if (!addrs_ok() || hit_dir !== 4'b0010 || bit_on !== 1'b1) begin
      errors++;
      $display("FAIL mid_clean got %b/%b want 1/0010", bit_on, hit_dir);
    end
  endtask

  task automatic test_random();
    int x, y, s;
    for (int n = 0; n < 24; n++) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
      s = $urandom_range(0, 30);
      solid.delete();
      if ($urandom_range(0, 1) == 1) solid[y * 640 + x - s - 1] = 1'b1;
      if ($urandom_range(0, 1) == 1) solid[y * 640 + x + s + 1] = 1'b1;
      if ($urandom_range(0, 1) == 1) solid[(y - s - 1) * 640 + x] = 1'b1;
      if ($urandom_range(0, 1) == 1) solid[(y + s + 1) * 640 + x] = 1'b1;
      solid[$urandom_range(0, 307199)] = 1'b1;
      model(x, y, s, 1'b0);
      do_frame(x, y, s);
      checks++;
      if (!addrs_ok()) begin
        errors++;
        $display("FAIL rand_addrs x=%0d y=%0d s=%0d got n=%0d want n=%0d",
                 x, y, s, addr_q.size(), exp_q.size());
      end
      checks++;
      if (hit_dir !== exp_hit || bit_on !== (exp_hit[1] | exp_hit[0])) begin
        errors++;
        $display("FAIL rand_hit x=%0d y=%0d s=%0d got %b/%b want %b",
                 x, y, s, bit_on, hit_dir, exp_hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_bottom();
    test_left_edge();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_collide.md
BALL_COLLIDE -- requirements
Module: ball_collide

Interface
REQ-001 Parameter H_RES, default 640, playfield width in pixels.
REQ-002 Parameter V_RES, default 480, playfield height in pixels.
REQ-003 Clk  input  1  system clock; one clock domain; all state changes on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 frame_clk  input  1  frame tick, asynchronous to Clk; its rising edge starts one probe sequence.
REQ-006 BallX, BallY  input  10 each  ball centre, in pixels.
REQ-007 BallS  input  10  ball half-size, in pixels.
REQ-008 mem_addr  output  19  playfield bitmap address = y*H_RES + x.
REQ-009 mem_rd  output  1  read strobe; mem_rdata is valid exactly 1 Clk after a cycle with mem_rd=1.
REQ-010 mem_rdata  input  1  playfield bit; 1 = solid pixel.
REQ-011 bit_on  output  1  registered horizontal-collision flag for the ball's frame_clk logic.
REQ-012 hit_dir  output  4  registered per-side hits {top, bottom, left, right}.
REQ-013 busy  output  1  high while a probe sequence is in progress.
REQ-014 overrun  output  1  sticky; set when a frame tick arrives while busy.

Function
REQ-015 frame_clk SHALL pass through a 2-flop synchronizer; a 0->1 transition of the synchronized signal SHALL produce a 1-Clk tick.
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN, UPDATE.
REQ-017 IDLE: on tick, latch BallX/BallY/BallS, clear probe counter, go to ISSUE; busy=1 from the next cycle.
REQ-018 ISSUE SHALL last 4 cycles, probe index 0..3 = left, right, top, bottom, one address per cycle.
REQ-019 Probe points, one pixel outside the ball edge: left (X-S-1, Y); right (X+S+1, Y); top (X, Y-S-1); bottom (X, Y+S+1).
REQ-020 Coordinate arithmetic SHALL be 11-bit signed; address = (y<<9)+(y<<7)+x, 19 bits, no multiplier.
REQ-021 A probe point with x<0, x>=H_RES, y<0 or y>=V_RES SHALL hold mem_rd=0 for that cycle and record a 0 result.
REQ-022 Each returned mem_rdata SHALL be captured into the result bit of the probe issued in the previous cycle.
REQ-023 DRAIN SHALL last 1 cycle to capture the bottom result, then go to UPDATE.
REQ-024 UPDATE SHALL load hit_dir from the captured bits, set bit_on = left|right, then go to IDLE with busy=0.
REQ-025 bit_on and hit_dir SHALL hold their value until the next UPDATE.
REQ-026 Latency from synchronized tick to updated bit_on SHALL be 7 Clk; from raw frame_clk edge, at most 9 Clk.
REQ-027 A tick while not in IDLE SHALL be dropped and SHALL set overrun; the sequence in progress is unaffected.
REQ-028 Input changes on BallX/BallY/BallS after the latch SHALL NOT affect the current sequence.
REQ-029 mem_addr SHALL be 0 whenever mem_rd=0.

Reset
REQ-030 Reset_n=0 SHALL act immediately, including mid-sequence: FSM to IDLE; bit_on, hit_dir, busy, overrun, mem_rd and mem_addr to 0; synchronizer flops to 0.
REQ-031 A high frame_clk present at reset release SHALL NOT generate a tick.
REQ-032 A partially completed sequence SHALL NOT update outputs after reset.

Structure
REQ-033 Package collide_pkg SHALL hold H_RES/V_RES defaults, ADDR_W=19, the state enum, and the probe-index constants PROBE_L/R/T/B.
REQ-034 Synchronizer plus edge detect SHALL be sub-module sync_rise (ports Clk, Reset_n, d, q_rise).

Verification
REQ-035 Bitmap all 0; X=320, Y=240, S=4; one tick -> addresses 153915, 153925, 150720, 157120 in order; bit_on=0, hit_dir=0000.
REQ-036 Solid pixel at (315,240) only (addr 153915); same ball -> bit_on=1, hit_dir=0010, exactly 7 Clk after the synchronized tick.
REQ-037 Solid pixel at (320,245) only; same ball -> bit_on=0, hit_dir=0100.
REQ-038 X=4, S=4: left probe at x=-1 -> only 3 mem_rd pulses; left result 0 even if mem_rdata is forced to 1.
REQ-039 Second frame_clk edge 3 Clk after the first tick -> overrun=1; exactly one UPDATE; result matches the first latched position.
REQ-040 Reset_n pulsed low during ISSUE -> all outputs 0 within the same cycle; no UPDATE follows; the next tick runs a clean sequence.
